// File: rtl/panel_cmd_sequencer.sv
// rtl/panel_cmd_sequencer.sv - PDP-8/e front-panel command sequencer
//
// Runs debounced front-panel command pulses against the panel PC/IF/DF/MB
// registers and memory while the CPU is halted.
//
// Optional feature macro: PANEL_LOCK_EN (adds the panel_lock input).
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   run                   CPU running (1) / halted (0)
//   sr                    switch register (octal value, panel bit 0 = MSB)
//   cleard .. contd       one-cycle command pulses from the debouncer
//   panel_lock            (PANEL_LOCK_EN only) discard all commands but clear
//   mem_req/we/addr/wdata memory request, held until mem_ack or timeout
//   mem_ack, mem_rdata    one-cycle completion with read data
//   pc, ifr, dfr, mb      panel registers
//   clear_out, cont_out   one-cycle CPU strobes
//   busy                  FSM active or commands pending
//   err                   sticky error, cleared by the clear command
//
// Panel bit numbering is big-endian (bit 0 = MSB). Vectors here are declared
// descending, so panel bit n of a 12-bit word is vector bit 11-n; the octal
// values on every port are the same either way.

module panel_cmd_sequencer #(
    parameter int TO_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
`ifdef PANEL_LOCK_EN
    input  logic        panel_lock,
`endif
    input  logic        run,
    input  logic [11:0] sr,
    input  logic        cleard,
    input  logic        extd_addrd,
    input  logic        addr_loadd,
    input  logic        depd,
    input  logic        examd,
    input  logic        contd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [11:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [11:0] mem_rdata,
    output logic [11:0] pc,
    output logic [2:0]  ifr,
    output logic [2:0]  dfr,
    output logic [11:0] mb,
    output logic        clear_out,
    output logic        cont_out,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_XADR, S_LOAD, S_MREQ, S_MWAIT, S_POST, S_CLR, S_CONT
    } state_t;

    // Pending-bit positions, highest index = highest dispatch priority.
    localparam int P_CLR  = 5;
    localparam int P_XADR = 4;
    localparam int P_LOAD = 3;
    localparam int P_DEP  = 2;
    localparam int P_EXAM = 1;
    localparam int P_CONT = 0;

    state_t             state;
    logic [5:0]         pending;
    logic [5:0]         pulses;
    logic [5:0]         eff;
    logic               op_dep;
    logic [TO_BITS-1:0] wd;
    logic [TO_BITS-1:0] wd_next;

    always_comb begin
        pulses = {cleard, extd_addrd, addr_loadd, depd, examd, contd};
`ifdef PANEL_LOCK_EN
        if (panel_lock) begin
            pulses = pulses & 6'b100000;
        end
`endif
        // Dispatch sees this cycle's pulses too, so LOAD/XADR land two
        // cycles after the pulse rather than three.
        eff     = pending | pulses;
        wd_next = wd + TO_BITS'(1);
    end

    assign busy = (state != S_IDLE) || (pending != 6'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pending   <= '0;
            op_dep    <= 1'b0;
            wd        <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pc        <= '0;
            ifr       <= '0;
            dfr       <= '0;
            mb        <= '0;
            clear_out <= 1'b0;
            cont_out  <= 1'b0;
            err       <= 1'b0;
        end else begin
            clear_out <= 1'b0;
            cont_out  <= 1'b0;
            pending   <= eff;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        // Only clear may act on a running CPU; everything
                        // else is thrown away and flagged.
                        pending <= '0;
                        if (eff[P_CLR]) state <= S_CLR;
                        if (eff[4:0] != 5'd0) err <= 1'b1;
                    end else if (eff[P_CLR]) begin
                        pending[P_CLR] <= 1'b0;
                        state <= S_CLR;
                    end else if (eff[P_XADR]) begin
                        pending[P_XADR] <= 1'b0;
                        state <= S_XADR;
                    end else if (eff[P_LOAD]) begin
                        pending[P_LOAD] <= 1'b0;
                        state <= S_LOAD;
                    end else if (eff[P_DEP]) begin
                        pending[P_DEP] <= 1'b0;
                        op_dep <= 1'b1;
                        wd     <= '0;
                        state  <= S_MREQ;
                    end else if (eff[P_EXAM]) begin
                        pending[P_EXAM] <= 1'b0;
                        op_dep <= 1'b0;
                        wd     <= '0;
                        state  <= S_MREQ;
                    end else if (eff[P_CONT]) begin
                        pending[P_CONT] <= 1'b0;
                        state <= S_CONT;
                    end
                end
                S_XADR: begin
                    ifr   <= sr[5:3];
                    dfr   <= sr[2:0];
                    state <= S_IDLE;
                end
                S_LOAD: begin
                    pc    <= sr;
                    state <= S_IDLE;
                end
                S_MREQ: begin
                    mem_req   <= 1'b1;
                    mem_we    <= op_dep;
                    mem_addr  <= {ifr, pc};
                    mem_wdata <= sr;
                    wd        <= '0;
                    state     <= S_MWAIT;
                end
                S_MWAIT: begin
                    if (mem_ack) begin
                        mb      <= mem_we ? mem_wdata : mem_rdata;
                        mem_req <= 1'b0;
                        state   <= S_POST;
                    end else begin
                        wd <= wd_next;
                        // Give up when the watchdog reaches all-ones:
                        // 2**TO_BITS-1 request cycles without an ack.
                        if (&wd_next) begin
                            mem_req <= 1'b0;
                            err     <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
                S_POST: begin
                    pc    <= pc + 12'd1;
                    state <= S_IDLE;
                end
                S_CLR: begin
                    clear_out <= 1'b1;
                    err       <= 1'b0;
                    state     <= S_IDLE;
                end
                S_CONT: begin
                    cont_out <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_panel_cmd_sequencer.sv
// tb/tb_panel_cmd_sequencer.sv - directed self-checking bench for panel_cmd_sequencer

module tb_panel_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [11:0] sr;
    logic        cleard, extd_addrd, addr_loadd, depd, examd, contd;
    logic        mem_req, mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic        mem_ack;
    logic [11:0] mem_rdata;
    logic [11:0] pc;
    logic [2:0]  ifr, dfr;
    logic [11:0] mb;
    logic        clear_out, cont_out, busy, err;
`ifdef PANEL_LOCK_EN
    logic        panel_lock;
`endif

    int checks = 0;
    int errors = 0;

    int          acc_cnt;
    logic [14:0] acc_addr;
    logic        acc_we;
    logic [11:0] acc_wdata;
    logic        acc_held;
    int          req_cycles;
    int          req_seen;

    panel_cmd_sequencer #(.TO_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef PANEL_LOCK_EN
        .panel_lock (panel_lock),
`endif
        .run        (run),
        .sr         (sr),
        .cleard     (cleard),
        .extd_addrd (extd_addrd),
        .addr_loadd (addr_loadd),
        .depd       (depd),
        .examd      (examd),
        .contd      (contd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .pc         (pc),
        .ifr        (ifr),
        .dfr        (dfr),
        .mb         (mb),
        .clear_out  (clear_out),
        .cont_out   (cont_out),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // p = {clear, extd_addr, addr_load, dep, exam, cont}; returns 1 ns after
    // the edge that sampled the pulse.
    task automatic pulse(input logic [5:0] p);
        {cleard, extd_addrd, addr_loadd, depd, examd, contd} = p;
        step();
        {cleard, extd_addrd, addr_loadd, depd, examd, contd} = 6'd0;
    endtask

    // Waits for a request, acks it after it has been seen high ack_after
    // times, and records the request fields from its first cycle.
    task automatic wait_ack(input int ack_after, input logic [11:0] rdata);
        logic done;
        done = 1'b0;
        acc_cnt = 0; acc_held = 1'b1;
        acc_addr = '0; acc_we = 1'b0; acc_wdata = '0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (mem_req) begin
                acc_cnt++;
                if (acc_cnt == 1) begin
                    acc_addr = mem_addr; acc_we = mem_we; acc_wdata = mem_wdata;
                end
            end else if (acc_cnt > 0) begin
                acc_held = 1'b0;
            end
            if (acc_cnt == ack_after) begin
                mem_ack = 1'b1; mem_rdata = rdata;
                step();
                mem_ack = 1'b0; mem_rdata = '0;
                done = 1'b1;
            end
        end
        check("ack_reached", 32'(done), 32'd1);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; sr = '0;
        {cleard, extd_addrd, addr_loadd, depd, examd, contd} = 6'd0;
        mem_ack = 1'b0; mem_rdata = '0;
`ifdef PANEL_LOCK_EN
        panel_lock = 1'b0;
`endif
        step(); step();
        reset = 1'b0;
        check("rst_req",  32'(mem_req), 0);
        check("rst_pc",   32'(pc), 0);
        check("rst_mb",   32'(mb), 0);
        check("rst_ifr",  32'(ifr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err",  32'(err), 0);
        check("rst_clr",  32'(clear_out), 0);

        // 1: address load
        sr = 12'o4000;
        pulse(6'b001000);
        check("t1_busy_mid", 32'(busy), 1);
        step();
        check("t1_pc", 32'(pc), 32'o4000);
        check("t1_busy_end", 32'(busy), 0);

        // 2: extended address, load 7777, deposit with wrap
        sr = 12'o0052;
        pulse(6'b010000);
        step();
        check("t2_ifr", 32'(ifr), 5);
        check("t2_dfr", 32'(dfr), 2);
        sr = 12'o7777;
        pulse(6'b001000);
        step();
        check("t2_pc_load", 32'(pc), 32'o7777);
        pulse(6'b000100);
        wait_ack(3, 12'o0000);
        check("t2_addr",  32'(acc_addr), 32'o57777);
        check("t2_we",    32'(acc_we), 1);
        check("t2_wdata", 32'(acc_wdata), 32'o7777);
        check("t2_held",  32'(acc_held), 1);
        check("t2_req_drop", 32'(mem_req), 0);
        check("t2_mb",    32'(mb), 32'o7777);
        step();
        check("t2_pc_wrap", 32'(pc), 0);
        check("t2_ifr_keep", 32'(ifr), 5);

        // 3: examine
        sr = 12'o0000;
        pulse(6'b000010);
        wait_ack(4, 12'o1234);
        check("t3_addr", 32'(acc_addr), 32'o50000);
        check("t3_we",   32'(acc_we), 0);
        check("t3_held", 32'(acc_held), 1);
        check("t3_cnt",  32'(acc_cnt), 4);
        check("t3_mb",   32'(mb), 32'o1234);
        step();
        check("t3_pc", 32'(pc), 1);

        // 4: simultaneous dep/exam/addr_load -> load, dep, exam
        sr = 12'o0100;
        pulse(6'b001110);
        wait_ack(1, 12'o3333);
        check("t4_dep_addr", 32'(acc_addr), 32'o50100);
        check("t4_dep_we",   32'(acc_we), 1);
        check("t4_dep_mb",   32'(mb), 32'o0100);
        wait_ack(2, 12'o3333);
        check("t4_exam_addr", 32'(acc_addr), 32'o50101);
        check("t4_exam_we",   32'(acc_we), 0);
        check("t4_exam_mb",   32'(mb), 32'o3333);
        step();
        check("t4_pc",   32'(pc), 32'o0102);
        check("t4_busy", 32'(busy), 0);

        // 5: watchdog timeout, then clear
        pulse(6'b000010);
        req_cycles = 0;
        req_seen = 0;
        for (int i = 0; i < 300 && !(req_seen == 1 && !mem_req); i++) begin
            step();
            if (mem_req) begin
                req_cycles++;
                req_seen = 1;
            end
        end
        check("t5_req_cycles", 32'(req_cycles), 255);
        check("t5_req_low", 32'(mem_req), 0);
        check("t5_err",     32'(err), 1);
        check("t5_pc",      32'(pc), 32'o0102);
        pulse(6'b100000);
        check("t5_clr_early", 32'(clear_out), 0);
        step();
        check("t5_clr_pulse", 32'(clear_out), 1);
        check("t5_err_clr",   32'(err), 0);
        step();
        check("t5_clr_end", 32'(clear_out), 0);

        // continue strobe
        pulse(6'b000001);
        check("cont_early", 32'(cont_out), 0);
        step();
        check("cont_pulse", 32'(cont_out), 1);
        step();
        check("cont_end", 32'(cont_out), 0);

        // 6: run=1 rejects deposit
        run = 1'b1;
        pulse(6'b000100);
        check("t6_err", 32'(err), 1);
        req_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_req) req_seen = 1;
        end
        check("t6_no_req", 32'(req_seen), 0);
        check("t6_busy",   32'(busy), 0);
        run = 1'b0;
        pulse(6'b100000);
        step();
        check("t6_err_clr", 32'(err), 0);

        // reset during MWAIT with a command pending
        pulse(6'b000010);
        step();
        check("t6_req_up", 32'(mem_req), 1);
        pulse(6'b000100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst_req",  32'(mem_req), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_pc",   32'(pc), 0);
        req_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (mem_req) req_seen = 1;
        end
        check("t6_rst_quiet", 32'(req_seen), 0);

`ifdef PANEL_LOCK_EN
        panel_lock = 1'b1;
        pulse(6'b000100);
        req_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_req) req_seen = 1;
        end
        check("lock_no_req", 32'(req_seen), 0);
        check("lock_err",    32'(err), 0);
        check("lock_busy",   32'(busy), 0);
        panel_lock = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
